l1v_yanitlayici: RTL and testbench

- Responder end of the L1 data-cache request/response interface.
- Accepts one load/store request at a time from the memory unit via a valid/ready handshake.
- Accesses a local word-organised data array with byte-mask writes after a parameterised latency.
- Returns one response per request on a valid/ready read-data channel.
- Serves as the data-side L1 model/scratchpad until the full cache controller exists.

---
 rtl/l1v_yanitlayici.sv | 202 ++++++++++++++++++++
 tb/tb_l1v_yanitlayici.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/l1v_yanitlayici.sv
// l1v_yanitlayici: responder end of the L1 data-side request/response port over a word array with byte-mask stores.
// Optional alignment/range checking and the l1v_hata_o port are enabled by `L1V_HIZALAMA_DENETIM_EN.
//
// state | meaning
// BOS   | idle, ready to accept a request
// BEKLE | request latched, counting down the access latency
// YANIT | response valid, held until l1v_veri_hazir_i
module l1v_yanitlayici #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32,
  parameter int SATIR     = 256,
  parameter int GECIKME   = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  l1v_istek_gecerli_i,
  output logic                  l1v_istek_hazir_o,
  input  logic [ADRES_BIT-1:0]  l1v_istek_adres_i,
  input  logic                  l1v_istek_yaz_i,
  input  logic [VERI_BIT-1:0]   l1v_istek_veri_i,
  input  logic [VERI_BIT/8-1:0] l1v_istek_maske_i,
  output logic [VERI_BIT-1:0]   l1v_veri_o,
  output logic                  l1v_veri_gecerli_o,
  input  logic                  l1v_veri_hazir_i
`ifdef L1V_HIZALAMA_DENETIM_EN
  ,
  output logic                  l1v_hata_o
`endif
);

  localparam int MASKE_BIT = VERI_BIT / 8;
  localparam int IDX_BIT   = $clog2(SATIR);
  localparam int SAYAC_BIT = 4;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  durum_t               durum_q, durum_d;
  logic                 hazir_q, hazir_d;
  logic                 gecerli_q, gecerli_d;
  logic [VERI_BIT-1:0]  veri_q, veri_d;
  logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
  logic [ADRES_BIT-1:0] adres_q, adres_d;
  logic                 yaz_q, yaz_d;
  logic [VERI_BIT-1:0]  wveri_q, wveri_d;
  logic [MASKE_BIT-1:0] maske_q, maske_d;
`ifdef L1V_HIZALAMA_DENETIM_EN
  logic                 hata_q, hata_d;
`endif

  logic [VERI_BIT-1:0]  dizi [SATIR];

  logic                 kabul;
  logic                 erisim;
  logic                 yaz_en;
  logic                 e_yaz;
  logic                 e_hata;
  logic [ADRES_BIT-1:0] e_adres;
  logic [VERI_BIT-1:0]  e_veri;
  logic [MASKE_BIT-1:0] e_maske;
  logic [IDX_BIT-1:0]   e_idx;
  logic [VERI_BIT-1:0]  yanit_veri;

  assign kabul = l1v_istek_gecerli_i && hazir_q;

  // With a one-cycle latency the array is accessed on the acceptance edge, straight from the request inputs.
  assign e_adres = (durum_q == BOS) ? l1v_istek_adres_i : adres_q;
  assign e_yaz   = (durum_q == BOS) ? l1v_istek_yaz_i   : yaz_q;
  assign e_veri  = (durum_q == BOS) ? l1v_istek_veri_i  : wveri_q;
  assign e_maske = (durum_q == BOS) ? l1v_istek_maske_i : maske_q;
  assign e_idx   = IDX_BIT'(e_adres >> 2);

  assign erisim = (durum_q == BOS) ? (kabul && (GECIKME == 1))
                                   : ((durum_q == BEKLE) && (sayac_q == SAYAC_BIT'(1)));

`ifdef L1V_HIZALAMA_DENETIM_EN
  assign e_hata = ((e_adres[1:0] != 2'b00) && (e_maske != '1)) ||
                  ((e_adres >> (IDX_BIT + 2)) != '0);
`else
  assign e_hata = 1'b0;
`endif

  assign yaz_en     = erisim && e_yaz && !e_hata;
  assign yanit_veri = (e_yaz || e_hata) ? '0 : dizi[e_idx];

  // Array contents are deliberately not reset so they survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (yaz_en) begin
      for (int b = 0; b < MASKE_BIT; b++) begin
        if (e_maske[b]) begin
          dizi[e_idx][8*b +: 8] <= e_veri[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    durum_d   = durum_q;
    hazir_d   = hazir_q;
    gecerli_d = gecerli_q;
    veri_d    = veri_q;
    sayac_d   = sayac_q;
    adres_d   = adres_q;
    yaz_d     = yaz_q;
    wveri_d   = wveri_q;
    maske_d   = maske_q;
`ifdef L1V_HIZALAMA_DENETIM_EN
    hata_d    = hata_q;
`endif
    case (durum_q)
      BOS: begin
        if (kabul) begin
          adres_d = l1v_istek_adres_i;
          yaz_d   = l1v_istek_yaz_i;
          wveri_d = l1v_istek_veri_i;
          maske_d = l1v_istek_maske_i;
          hazir_d = 1'b0;
          if (GECIKME == 1) begin
            durum_d   = YANIT;
            gecerli_d = 1'b1;
            veri_d    = yanit_veri;
`ifdef L1V_HIZALAMA_DENETIM_EN
            hata_d    = e_hata;
`endif
          end else begin
            durum_d = BEKLE;
            sayac_d = SAYAC_BIT'(GECIKME - 1);
          end
        end
      end
      BEKLE: begin
        sayac_d = sayac_q - SAYAC_BIT'(1);
        if (sayac_q == SAYAC_BIT'(1)) begin
          durum_d   = YANIT;
          gecerli_d = 1'b1;
          veri_d    = yanit_veri;
`ifdef L1V_HIZALAMA_DENETIM_EN
          hata_d    = e_hata;
`endif
        end
      end
      YANIT: begin
        if (l1v_veri_hazir_i) begin
          durum_d   = BOS;
          gecerli_d = 1'b0;
          hazir_d   = 1'b1;
          veri_d    = '0;
`ifdef L1V_HIZALAMA_DENETIM_EN
          hata_d    = 1'b0;
`endif
        end
      end
      default: begin
        durum_d   = BOS;
        hazir_d   = 1'b1;
        gecerli_d = 1'b0;
        veri_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= BOS;
      hazir_q   <= 1'b1;
      gecerli_q <= 1'b0;
      veri_q    <= '0;
      sayac_q   <= '0;
      adres_q   <= '0;
      yaz_q     <= 1'b0;
      wveri_q   <= '0;
      maske_q   <= '0;
`ifdef L1V_HIZALAMA_DENETIM_EN
      hata_q    <= 1'b0;
`endif
    end else begin
      durum_q   <= durum_d;
      hazir_q   <= hazir_d;
      gecerli_q <= gecerli_d;
      veri_q    <= veri_d;
      sayac_q   <= sayac_d;
      adres_q   <= adres_d;
      yaz_q     <= yaz_d;
      wveri_q   <= wveri_d;
      maske_q   <= maske_d;
`ifdef L1V_HIZALAMA_DENETIM_EN
      hata_q    <= hata_d;
`endif
    end
  end

  assign l1v_istek_hazir_o  = hazir_q;
  assign l1v_veri_gecerli_o = gecerli_q;
  assign l1v_veri_o         = veri_q;
`ifdef L1V_HIZALAMA_DENETIM_EN
  assign l1v_hata_o         = hata_q;
`endif

endmodule

// File: tb/tb_l1v_yanitlayici.sv
// Bench for l1v_yanitlayici: a GECIKME=2 instance for directed traffic and a GECIKME=1 instance for back-to-back traffic.
// Expected responses come from a word-array model through scoreboard queues; `L1V_HIZALAMA_DENETIM_EN adds hata checks.
module tb_l1v_yanitlayici;

  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        gec, yaz, vhaz, ihaz, vgec;
  logic [31:0] adr, wd, vout;
  logic [3:0]  msk;
  logic        b_gec, b_yaz, b_vhaz, b_ihaz, b_vgec;
  logic [31:0] b_adr, b_wd, b_vout;
  logic [3:0]  b_msk;
`ifdef L1V_HIZALAMA_DENETIM_EN
  logic        hata, b_hata;
`endif

  typedef struct packed {
    logic [31:0] veri;
    logic        hata;
  } bek_t;

  bek_t        q[$];
  bek_t        q1[$];
  logic [31:0] mdl [256];
  int          n_cmp = 0;
  int          n_err = 0;

  l1v_yanitlayici #(.ADRES_BIT(32), .VERI_BIT(32), .SATIR(256), .GECIKME(G)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .l1v_istek_gecerli_i(gec), .l1v_istek_hazir_o(ihaz), .l1v_istek_adres_i(adr),
    .l1v_istek_yaz_i(yaz), .l1v_istek_veri_i(wd), .l1v_istek_maske_i(msk),
    .l1v_veri_o(vout), .l1v_veri_gecerli_o(vgec), .l1v_veri_hazir_i(vhaz)
`ifdef L1V_HIZALAMA_DENETIM_EN
    , .l1v_hata_o(hata)
`endif
  );

  l1v_yanitlayici #(.ADRES_BIT(32), .VERI_BIT(32), .SATIR(256), .GECIKME(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .l1v_istek_gecerli_i(b_gec), .l1v_istek_hazir_o(b_ihaz), .l1v_istek_adres_i(b_adr),
    .l1v_istek_yaz_i(b_yaz), .l1v_istek_veri_i(b_wd), .l1v_istek_maske_i(b_msk),
    .l1v_veri_o(b_vout), .l1v_veri_gecerli_o(b_vgec), .l1v_veri_hazir_i(b_vhaz)
`ifdef L1V_HIZALAMA_DENETIM_EN
    , .l1v_hata_o(b_hata)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic hata_mi(input logic [31:0] a, input logic [3:0] m);
`ifdef L1V_HIZALAMA_DENETIM_EN
    return ((a[1:0] != 2'b00) && (m != 4'hF)) || (a >= 32'd1024);
`else
    return 1'b0 & a[0] & m[0];
`endif
  endfunction

  // One request on the GECIKME=2 instance; tut > 0 holds the response off for that many extra cycles.
  task automatic istek(input logic [31:0] a, input logic y, input logic [31:0] d,
                       input logic [3:0] m, input int tut);
    bek_t        e;
    bek_t        g;
    int          n;
    logic [7:0]  i;
    logic [31:0] tutulan;
    i      = a[9:2];
    e.hata = hata_mi(a, m);
    e.veri = (y || e.hata) ? 32'h0 : mdl[i];
    if (y && !e.hata) begin
      for (int b = 0; b < 4; b++) if (m[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
    end
    vhaz = (tut == 0);
    n = 0;
    while (!ihaz && n < 20) begin @(negedge clk); n++; end
    chk("kabul_zaman_asimi", 32'(n < 20), 32'd1);
    q.push_back(e);
    gec = 1'b1; adr = a; yaz = y; wd = d; msk = m;
    @(negedge clk);
    gec = 1'b0; adr = $urandom; yaz = ~y; wd = $urandom; msk = 4'($urandom);
    n = 1;
    while (!vgec && n < 20) begin
      chk("bekle_hazir", 32'(ihaz), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("gecikme", n, G);
    g = q.pop_front();
    chk("yanit_veri", vout, g.veri);
    chk("yanit_hazir", 32'(ihaz), 32'd0);
`ifdef L1V_HIZALAMA_DENETIM_EN
    chk("yanit_hata", 32'(hata), 32'(g.hata));
`endif
    tutulan = vout;
    for (int k = 0; k < tut; k++) begin
      gec = (k == 2); adr = 32'h20; yaz = 1'b1; wd = 32'hFFFF_FFFF; msk = 4'hF;
      @(negedge clk);
      chk("tutma_gecerli", 32'(vgec), 32'd1);
      chk("tutma_veri", vout, tutulan);
      chk("tutma_hazir", 32'(ihaz), 32'd0);
    end
    gec = 1'b0;
    vhaz = 1'b1;
    @(negedge clk);
    chk("el_sikisma_gecerli", 32'(vgec), 32'd0);
    chk("el_sikisma_hazir", 32'(ihaz), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bek_t        g;
    int          ni, nr, son;
    logic [31:0] b_adrs [8];
    logic [31:0] b_wds  [8];
    logic        b_yazs [8];

    rstn = 1'b0; gec = 1'b0; yaz = 1'b0; vhaz = 1'b1; adr = '0; wd = '0; msk = '0;
    b_gec = 1'b0; b_yaz = 1'b0; b_vhaz = 1'b1; b_adr = '0; b_wd = '0; b_msk = '0;
    @(negedge clk);
    chk("reset_hazir", 32'(ihaz), 32'd1);
    chk("reset_gecerli", 32'(vgec), 32'd0);
    chk("reset_veri", vout, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    istek(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    istek(32'h10, 1'b0, 32'h0, 4'hF, 0);

    istek(32'h20, 1'b1, 32'h1122_3344, 4'hF, 0);
    istek(32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, 0);
    istek(32'h20, 1'b0, 32'h0, 4'hF, 5);
    istek(32'h20, 1'b0, 32'h0, 4'hF, 0);
    istek(32'h20, 1'b1, 32'h0, 4'h0, 0);
    istek(32'h22, 1'b0, 32'h0, 4'hF, 0);

    istek(32'h0, 1'b1, 32'h0102_0304, 4'hF, 0);
    istek(32'h400, 1'b1, 32'hCAFE_F00D, 4'hF, 0);
    istek(32'h0, 1'b0, 32'h0, 4'hF, 0);
    istek(32'h3FC, 1'b1, 32'hA5A5_5A5A, 4'hF, 0);
    istek(32'h3FC, 1'b0, 32'h0, 4'hF, 0);

    istek(32'h30, 1'b1, 32'h55AA_55AA, 4'hF, 0);
    gec = 1'b1; adr = 32'h30; yaz = 1'b1; wd = 32'h1234_5678; msk = 4'hF;
    @(negedge clk);
    gec = 1'b0;
    chk("bekle_oncesi_hazir", 32'(ihaz), 32'd0);
    rstn = 1'b0;
    #1;
    chk("reset_ara_gecerli", 32'(vgec), 32'd0);
    chk("reset_ara_hazir", 32'(ihaz), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_sonrasi_gecerli", 32'(vgec), 32'd0);
    istek(32'h30, 1'b0, 32'h0, 4'hF, 0);

    for (int k = 0; k < 4; k++) begin
      b_adrs[k]     = 32'h40 + 32'(4 * k);
      b_wds[k]      = 32'h1357_9BDF ^ (32'h0101_0101 * 32'(k + 1));
      b_yazs[k]     = 1'b1;
      b_adrs[k + 4] = b_adrs[k];
      b_wds[k + 4]  = 32'h0;
      b_yazs[k + 4] = 1'b0;
    end
    ni = 0; nr = 0; son = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_vgec) begin
        if (q1.size() == 0) begin
          chk("b2b_fazla_yanit", 32'(b_vgec), 32'd0);
        end else begin
          g = q1.pop_front();
          chk("b2b_veri", b_vout, g.veri);
          if (son >= 0) chk("b2b_aralik", c - son, 2);
        end
        son = c;
        nr++;
      end
      if (b_ihaz && ni < 8) begin
        g.veri = b_yazs[ni] ? 32'h0 : b_wds[ni - 4];
        g.hata = 1'b0;
        q1.push_back(g);
        b_gec = 1'b1; b_adr = b_adrs[ni]; b_yaz = b_yazs[ni]; b_wd = b_wds[ni]; b_msk = 4'hF;
        ni++;
      end else begin
        b_gec = 1'b0;
      end
    end
    chk("b2b_adet", nr, 8);
    chk("b2b_kuyruk_bos", q1.size(), 0);
    chk("kuyruk_bos", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
